// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of an SPI memory engine
// Fetch and data ports share one engine; mem_start is a clean registered level per transaction.
module mem_arbiter #(
    parameter int RELEASE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [24:0] f_addr,
    input  logic [2:0]  f_num_bytes,
    output logic        f_done,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [24:0] d_addr,
    input  logic [2:0]  d_num_bytes,
    input  logic        d_is_write,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_start,
    output logic [24:0] mem_addr,
    output logic [2:0]  mem_num_bytes,
    output logic        mem_is_write,
    output logic [31:0] mem_wdata,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant,
    output logic        err
);
    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [3:0]    REL_LAST = 4'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic [3:0]    rel_cnt;
    logic          rr_last;
    logic          win_data;

    // rr_last resets to "fetch went last" so data wins the first contended grant,
    // while the visible grant output resets to 1.
    always_comb begin
        win_data = d_req;
        if (f_req && d_req) begin
            win_data = ~rr_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            to_cnt        <= '0;
            rel_cnt       <= '0;
            rr_last       <= 1'b0;
            mem_start     <= 1'b0;
            mem_addr      <= '0;
            mem_num_bytes <= '0;
            mem_is_write  <= 1'b0;
            mem_wdata     <= '0;
            f_done        <= 1'b0;
            d_done        <= 1'b0;
            f_rdata       <= '0;
            d_rdata       <= '0;
            busy          <= 1'b0;
            grant         <= 1'b1;
            err           <= 1'b0;
        end else begin
            f_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (f_req || d_req) begin
                        state     <= ISSUE;
                        mem_start <= 1'b1;
                        busy      <= 1'b1;
                        grant     <= win_data;
                        rr_last   <= win_data;
                        to_cnt    <= '0;
                        if (win_data) begin
                            mem_addr      <= d_addr;
                            mem_num_bytes <= d_num_bytes;
                            mem_is_write  <= d_is_write;
                            mem_wdata     <= d_wdata;
                        end else begin
                            mem_addr      <= f_addr;
                            mem_num_bytes <= f_num_bytes;
                            mem_is_write  <= 1'b0;
                            mem_wdata     <= '0;
                        end
                    end
                end
                ISSUE: begin
                    // A real completion on the timeout cycle takes precedence over the abort.
                    if (mem_done || (TO_EN && to_cnt == TO_LAST)) begin
                        state     <= RELEASE;
                        mem_start <= 1'b0;
                        rel_cnt   <= '0;
                        if (!mem_done) begin
                            err <= 1'b1;
                        end
                        if (grant) begin
                            d_done  <= 1'b1;
                            d_rdata <= mem_done ? mem_rdata : 32'hFFFF_FFFF;
                        end else begin
                            f_done  <= 1'b1;
                            f_rdata <= mem_done ? mem_rdata : 32'hFFFF_FFFF;
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Timestamp-based transaction model compared every negedge, plus directed literal checks.
module tb_mem_arbiter;
    localparam int REL = 2;
    localparam int TO  = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req, d_req, d_is_write, mem_done;
    logic [24:0] f_addr, d_addr;
    logic [2:0]  f_num_bytes, d_num_bytes;
    logic [31:0] d_wdata, mem_rdata;
    logic        f_done, d_done, mem_start, mem_is_write, busy, grant, err;
    logic [31:0] f_rdata, d_rdata, mem_wdata;
    logic [24:0] mem_addr;
    logic [2:0]  mem_num_bytes;

    mem_arbiter #(.RELEASE_CYCLES(REL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_num_bytes(f_num_bytes),
        .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_num_bytes(d_num_bytes),
        .d_is_write(d_is_write), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_start(mem_start), .mem_addr(mem_addr), .mem_num_bytes(mem_num_bytes),
        .mem_is_write(mem_is_write), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .busy(busy), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model: transactions described by their start/end cycle ----------------
    int          cyc = 0;
    int          m_start, m_end, m_last, m_owner;
    bit          m_active;
    logic [24:0] e_addr;
    logic [2:0]  e_nb;
    logic        e_wr, e_err, e_grant;
    logic [31:0] e_wdata, e_frd, e_drd;

    function automatic int phase_of(input int c);
        if (!m_active) return 0;
        if (m_end < 0 || c < m_end) return 1;
        if (c < m_end + REL) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_start = 0; m_end = -1; m_last = -1; m_owner = 0;
        e_addr = '0; e_nb = '0; e_wr = 1'b0; e_wdata = '0;
        e_frd = '0; e_drd = '0; e_err = 1'b0; e_grant = 1'b1;
    endtask

    task automatic model_finish(input logic [31:0] v, input bit timed_out);
        m_end = cyc + 1;
        if (m_owner == 1) e_drd = v; else e_frd = v;
        if (timed_out) e_err = 1'b1;
    endtask

    initial begin
        int p;
        bit want_d;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                p = phase_of(cyc);
                if (p == 1) begin
                    if (mem_done) model_finish(mem_rdata, 1'b0);
                    else if (cyc - m_start + 1 == TO) model_finish(32'hFFFF_FFFF, 1'b1);
                end else if (p == 0 && (f_req || d_req)) begin
                    want_d   = (f_req && d_req) ? (m_last != 1) : d_req;
                    m_owner  = want_d ? 1 : 0;
                    m_last   = m_owner;
                    e_grant  = want_d;
                    m_active = 1'b1;
                    m_start  = cyc + 1;
                    m_end    = -1;
                    e_addr   = want_d ? d_addr : f_addr;
                    e_nb     = want_d ? d_num_bytes : f_num_bytes;
                    e_wr     = want_d ? d_is_write : 1'b0;
                    e_wdata  = want_d ? d_wdata : 32'h0;
                end
                cyc++;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    int ncyc = 0;
    int fdone_cnt = 0;
    int ddone_cnt = 0;
    int gseq[$];
    int rises[$];

    initial begin
        int   p;
        logic prev_ms;
        prev_ms = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            p = phase_of(cyc);
            chk("mem_start", mem_start, p == 1);
            chk("busy", busy, p != 0);
            chk("grant", grant, e_grant);
            chk("err", err, e_err);
            chk("f_done", f_done, p == 2 && cyc == m_end && m_owner == 0);
            chk("d_done", d_done, p == 2 && cyc == m_end && m_owner == 1);
            chk("f_rdata", f_rdata, e_frd);
            chk("d_rdata", d_rdata, e_drd);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_num_bytes", mem_num_bytes, e_nb);
            chk("mem_is_write", mem_is_write, e_wr);
            chk("mem_wdata", mem_wdata, e_wdata);
            if (f_done) fdone_cnt++;
            if (d_done) ddone_cnt++;
            if (mem_start && !prev_ms) begin
                gseq.push_back(int'(grant));
                rises.push_back(ncyc);
            end
            prev_ms = mem_start;
        end
    end

    // ---------------- requesters and memory engine ----------------
    int          f_left = 0;
    int          d_left = 0;
    int          eng_lat = 0;
    int          issue_n = 0;
    int          txn_no = 0;
    logic [31:0] eng_data = 32'h0;
    bit          stray = 1'b0;

    initial begin
        f_req = 1'b0; d_req = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (f_done && f_left > 0) f_left--;
            if (d_done && d_left > 0) d_left--;
            @(posedge clk);
            #1;
            f_req = (f_left > 0);
            d_req = (d_left > 0);
            if (mem_start) begin
                issue_n++;
                if (eng_lat != 0 && issue_n >= eng_lat) begin
                    if (!mem_done) begin
                        mem_rdata = eng_data + 32'(txn_no);
                        txn_no++;
                    end
                    mem_done = 1'b1;
                end
            end else begin
                issue_n = 0;
                if (!stray) mem_done = 1'b0;
            end
        end
    end

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_quiet(input string name, input int limit);
        int n;
        n = 0;
        while (!(f_left == 0 && d_left == 0 && !busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < limit, 1'b1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int          hi, bad, f0, d0, g0, r0;
        bit          seen;
        logic [31:0] exp_rd;
        f_addr = '0; f_num_bytes = '0; d_addr = '0; d_num_bytes = '0;
        d_is_write = 1'b0; d_wdata = '0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_grant", grant, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_start", mem_start, 0);
        chk("rst_err", err, 0);
        chk("rst_f_rdata", f_rdata, 0);
        rst_n = 1'b1;

        // single fetch, 70-cycle engine
        settle();
        f_addr = 25'h000100; f_num_bytes = 3'd4;
        eng_lat = 70; eng_data = 32'hDEAD_BEEF; txn_no = 0;
        f0 = fdone_cnt;
        f_left = 1;
        hi = 0; bad = 0; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (mem_start) begin
                hi++;
                if (mem_is_write !== 1'b0 || mem_addr !== 25'h000100) bad++;
            end
            if (f_done) seen = 1'b1;
        end
        chk("a_done_seen", seen, 1);
        chk("a_f_rdata", f_rdata, 32'hDEAD_BEEF);
        chk("a_issue_len", hi, 70);
        chk("a_fields", bad, 0);
        chk("a_rel1_start", mem_start, 0);
        @(negedge clk);
        chk("a_rel2_start", mem_start, 0);
        chk("a_rel2_busy", busy, 1);
        @(negedge clk);
        chk("a_idle_busy", busy, 0);
        wait_quiet("a_quiet", 50);
        chk("a_fdone_cnt", fdone_cnt - f0, 1);

        // mem_done outside ISSUE must do nothing
        settle();
        stray = 1'b1; mem_done = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        repeat (3) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_f_rdata", f_rdata, 32'hDEAD_BEEF);
        settle();
        stray = 1'b0; mem_done = 1'b0;

        // simultaneous requests straight after reset: data first
        pulse_reset();
        settle();
        eng_lat = 3; eng_data = 32'h5000_0000; txn_no = 0;
        d_addr = 25'h0000200; d_num_bytes = 3'd2;
        g0 = gseq.size(); f0 = fdone_cnt; d0 = ddone_cnt;
        f_left = 1; d_left = 1;
        wait_quiet("b_quiet", 100);
        chk("b_grants", gseq.size() - g0, 2);
        if (gseq.size() >= g0 + 2) begin
            chk("b_grant0", gseq[g0], 1);
            chk("b_grant1", gseq[g0 + 1], 0);
        end
        chk("b_fdone_cnt", fdone_cnt - f0, 1);
        chk("b_ddone_cnt", ddone_cnt - d0, 1);
        chk("b_d_rdata", d_rdata, 32'h5000_0000);
        chk("b_f_rdata", f_rdata, 32'h5000_0001);

        // sustained contention: alternation and start-to-start spacing
        settle();
        eng_lat = 4; eng_data = 32'hA500_0000; txn_no = 0;
        g0 = gseq.size();
        f_left = 3; d_left = 3;
        wait_quiet("c_quiet", 200);
        chk("c_grants", gseq.size() - g0, 6);
        if (gseq.size() >= g0 + 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("c_rr_grant", gseq[g0 + i], (i % 2 == 0) ? 1 : 0);
                if (i > 0) chk("c_spacing", rises[g0 + i] - rises[g0 + i - 1], 4 + REL + 1);
            end
        end

        // data write: fields held for the whole ISSUE window
        settle();
        d_addr = 25'h1000040; d_num_bytes = 3'd4; d_is_write = 1'b1; d_wdata = 32'h1122_3344;
        eng_lat = 5; eng_data = 32'h7700_0000; txn_no = 0;
        d0 = ddone_cnt;
        d_left = 1;
        hi = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_start) begin
                hi++;
                if (mem_addr !== 25'h1000040 || mem_is_write !== 1'b1 ||
                    mem_wdata !== 32'h1122_3344) bad++;
            end
        end
        chk("d_issue_len", hi, 5);
        chk("d_fields", bad, 0);
        chk("d_ddone_cnt", ddone_cnt - d0, 1);
        chk("d_wr_rdata", d_rdata, 32'h7700_0000);
        wait_quiet("d_quiet", 50);

        // timeout, then a following request is still served
        settle();
        d_is_write = 1'b0; d_addr = 25'h0000300;
        eng_lat = 0;
        d_left = 1;
        hi = 0; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (mem_start) hi++;
            if (d_done) seen = 1'b1;
        end
        chk("e_done_seen", seen, 1);
        chk("e_issue_len", hi, TO);
        chk("e_err", err, 1);
        chk("e_d_rdata", d_rdata, 32'hFFFF_FFFF);
        wait_quiet("e_quiet1", 50);
        settle();
        eng_lat = 3; eng_data = 32'h0BAD_F00D; txn_no = 0;
        f_left = 1;
        wait_quiet("e_quiet2", 50);
        chk("e_next_f_rdata", f_rdata, 32'h0BAD_F00D);
        chk("e_err_sticky", err, 1);

        // reset at ISSUE cycle 10, held data request is reissued
        settle();
        eng_lat = 0;
        d0 = ddone_cnt; r0 = rises.size();
        d_left = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_start) seen = 1'b1;
        end
        chk("f_issue_seen", seen, 1);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("f_rst_mem_start", mem_start, 0);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_err", err, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        eng_lat = 6; eng_data = 32'h600D_0000; txn_no = 0;
        exp_rd = 32'h600D_0000;
        wait_quiet("f_quiet", 100);
        chk("f_ddone_cnt", ddone_cnt - d0, 1);
        chk("f_reissued", rises.size() - r0, 2);
        chk("f_last_grant", gseq[gseq.size() - 1], 1);
        chk("f_d_rdata", d_rdata, exp_rd);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RELEASE_CYCLES, default 2, number of cycles mem_start is held low between transactions (legal range 1-15).
REQ-002 Parameter: TIMEOUT_CYCLES, default 200, cycles of ISSUE without mem_done before abort; 0 disables the timeout.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 f_req  input  1  fetch port request; level, held with f_addr/f_num_bytes stable until f_done.
REQ-006 f_addr  input  25  fetch address; bit 24 selects the RAM chip (1) or the flash chip (0).
REQ-007 f_num_bytes  input  3  fetch size (1, 2, other = 4 bytes).
REQ-008 f_done  output  1  one-cycle pulse: fetch transaction complete.
REQ-009 f_rdata  output  32  fetch read data, valid on and after f_done until the next fetch grant.
REQ-010 d_req / d_addr[24:0] / d_num_bytes[2:0]  input  data port request, address and size; same holding rules as the fetch port.
REQ-011 d_is_write  input  1  1 = write, 0 = read.
REQ-012 d_wdata  input  32  data-port write value.
REQ-013 d_done  output  1  one-cycle pulse: data transaction complete.
REQ-014 d_rdata  output  32  data-port read data (write: last mem_rdata captured), valid on and after d_done.
REQ-015 mem_start  output  1  level start to the SPI memory engine.
REQ-016 mem_addr[24:0] / mem_num_bytes[2:0] / mem_is_write / mem_wdata[31:0]  output  latched fields of the granted request.
REQ-017 mem_done  input  1  level completion from the engine.
REQ-018 mem_rdata  input  32  engine read data.
REQ-019 busy  output  1  high in any state except IDLE.
REQ-020 grant  output  1  owner of the current or last transaction: 0 = fetch, 1 = data.
REQ-021 err  output  1  sticky timeout flag; cleared only by reset.

Function
REQ-022 States: IDLE, ISSUE, RELEASE.
REQ-023 IDLE: a pending request is granted in the same cycle; the next cycle enters ISSUE with the mem_* fields latched from the winner.
REQ-024 Fetch port drives mem_is_write=0 and mem_wdata=0.
REQ-025 Arbitration: a single pending request wins; when both are pending, the port not granted last wins (round-robin); after reset, data has priority.
REQ-026 ISSUE: mem_start=1 and the mem_* fields are held constant; the timeout counter increments each cycle.
REQ-027 ISSUE with mem_done=1: capture mem_rdata into the granted port's rdata register, pulse that port's done in the next cycle, and enter RELEASE.
REQ-028 RELEASE: mem_start=0 for exactly RELEASE_CYCLES cycles, then IDLE.
REQ-029 Back-to-back requests: minimum spacing between mem_start rising edges = transaction time + RELEASE_CYCLES + 1.
REQ-030 Timeout: when the counter reaches TIMEOUT_CYCLES in ISSUE, set err, pulse the granted port's done with rdata = 32'hFFFFFFFF, and enter RELEASE.
REQ-031 mem_done asserted outside ISSUE is ignored.
REQ-032 A req dropped while granted does not cancel the transaction; done still pulses.
REQ-033 A request arriving during ISSUE or RELEASE waits for IDLE; no request is ever lost while req is held.
REQ-034 mem_start rises only from IDLE→ISSUE and falls only on ISSUE exit; no glitches.

Reset
REQ-035 Asynchronous reset: state=IDLE, mem_start=0, all mem_* fields=0, f_done=d_done=0, f_rdata=d_rdata=0, busy=0, grant=1, err=0, counters=0.
REQ-036 Reset mid-transaction drops mem_start immediately, with no done pulse; after release, pending requests are re-arbitrated from IDLE.

Verification
REQ-037 Single fetch: f_req, f_addr=0x000100, f_num_bytes=4; mem_done after 70 cycles with mem_rdata=0xDEADBEEF -> one f_done pulse, f_rdata=0xDEADBEEF, mem_is_write=0, then mem_start low for 2 cycles.
REQ-038 Simultaneous requests after reset: f_req and d_req both asserted -> data served first, then fetch; both done pulses seen, and grant sequence is 1, 0.
REQ-039 Sustained contention: both ports held requesting for 6 transactions -> grants alternate 1,0,1,0,1,0.
REQ-040 Data write: d_addr=0x1000040, d_is_write=1, d_wdata=0x11223344 -> mem_addr=0x1000040, mem_is_write=1, mem_wdata=0x11223344 through all of ISSUE; d_done pulses once.
REQ-041 Timeout: TIMEOUT_CYCLES=200, mem_done never asserted -> after 200 ISSUE cycles, err=1, d_rdata=0xFFFFFFFF, d_done pulses, and the next request is still served.
REQ-042 Reset mid-ISSUE: rst_n pulsed low at ISSUE cycle 10 -> mem_start=0 asynchronously, no done pulse, and a held request is reissued after reset.
